// File: rtl/sequence_transmitter_pkg.sv
// sequence_transmitter_pkg: FSM encoding and constants shared with the sequence detectors
package sequence_transmitter_pkg;
  typedef enum logic [1:0] {IDLE, SEND, GAP_ST, FINISH} state_t;
  localparam logic [5:0] DEFAULT_PATTERN = 6'b101_011;
  localparam logic FOUND = 1'b1;
  localparam logic NOT_FOUND = 1'b0;
endpackage

// File: rtl/sequence_transmitter_gap_counter.sv
// gap_counter: loadable down-counter with zero flag, used for bit index and gap length
module gap_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] init,
  output logic [W-1:0] count,
  output logic         zero
);
  assign zero = count == '0;
  // load has priority over decrement
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (load) count <= init;
    else if (dec) count <= count - W'(1);
endmodule

// File: rtl/sequence_transmitter.sv
// sequence_transmitter: emits a latched word MSB-first for N frames with idle gaps
module sequence_transmitter
  import sequence_transmitter_pkg::*;
#(
  parameter int               WIDTH   = 6,
  parameter logic [WIDTH-1:0] PATTERN = DEFAULT_PATTERN,
  parameter int               GAP     = 1,
  parameter int               CNT_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             use_pattern,
  input  logic [WIDTH-1:0] word_in,
  input  logic [CNT_W-1:0] frames,
  output logic             data_out,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] frames_sent
);
  localparam int MAXV = WIDTH > GAP ? WIDTH : GAP;
  localparam int CW = MAXV > 1 ? $clog2(MAXV) : 1;
  localparam logic [CW-1:0] IDX_LD = CW'(WIDTH - 1);
  localparam logic [CW-1:0] GAP_LD = CW'(GAP > 0 ? GAP - 1 : 0);
  state_t state, state_nxt;
  logic [WIDTH-1:0] word_q;
  logic [CNT_W-1:0] frames_q, fs_inc;
  logic [CW-1:0] cnt;
  logic cnt_zero, cnt_load, active;
  assign active = state == SEND || state == GAP_ST;
  assign cnt_load = !active || cnt_zero;
  assign fs_inc = frames_sent + CNT_W'(1);
  // one counter walks the bit index in SEND and the gap length in GAP_ST
  gap_counter #(.W(CW)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .dec   (active),
    .init  (state_nxt == GAP_ST ? GAP_LD : IDX_LD),
    .count (cnt),
    .zero  (cnt_zero)
  );
  // next state: frame ends when the index reaches 0, burst ends when the frame count is met
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? (frames != '0 ? SEND : FINISH) : IDLE;
      SEND:    state_nxt = !cnt_zero ? SEND : fs_inc == frames_q ? FINISH : GAP > 0 ? GAP_ST : SEND;
      GAP_ST:  state_nxt = cnt_zero ? SEND : GAP_ST;
      default: state_nxt = IDLE;
    endcase
  end
  // state, burst parameters latched on start, and registered outputs
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      word_q <= '0;
      frames_q <= '0;
      frames_sent <= '0;
      data_out <= 1'b0;
      valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        word_q <= use_pattern ? PATTERN : word_in;
        frames_q <= frames;
        frames_sent <= '0;
      end
      if (state == SEND && cnt_zero && frames_sent != frames_q) frames_sent <= fs_inc;
      data_out <= state == SEND && word_q[cnt];
      valid <= state == SEND;
      busy <= active;
      done <= state == FINISH;
    end
endmodule

// File: tb/tb_sequence_transmitter.sv
// tb_sequence_transmitter: randomized bursts on GAP=1 and GAP=0 instances against a timing-formula model
module tb_sequence_transmitter;
  localparam int W = 6;
  localparam int CW = 4;
  localparam logic [W-1:0] PAT = 6'b101_011;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start [2] = '{1'b0, 1'b0};
  logic use_pattern = 1'b0;
  logic [W-1:0] word_in = '0;
  logic [CW-1:0] frames = '0;
  logic data_out [2], valid [2], busy [2], done [2];
  logic [CW-1:0] fs [2];
  int n_cmp = 0, n_bad = 0, last_n = 0;
  // free-running clock
  always #5 clk = ~clk;
  sequence_transmitter #(.WIDTH(W), .PATTERN(PAT), .GAP(1), .CNT_W(CW)) u_gap1 (
    .clk(clk), .reset(reset), .start(start[0]), .use_pattern(use_pattern), .word_in(word_in),
    .frames(frames), .data_out(data_out[0]), .valid(valid[0]), .busy(busy[0]), .done(done[0]),
    .frames_sent(fs[0])
  );
  sequence_transmitter #(.WIDTH(W), .PATTERN(PAT), .GAP(0), .CNT_W(CW)) u_gap0 (
    .clk(clk), .reset(reset), .start(start[1]), .use_pattern(use_pattern), .word_in(word_in),
    .frames(frames), .data_out(data_out[1]), .valid(valid[1]), .busy(busy[1]), .done(done[1]),
    .frames_sent(fs[1])
  );
  function automatic int gap_of(int sel);
    return sel == 0 ? 1 : 0;
  endfunction
  task automatic check(string tag, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  task automatic check_outs(int sel, string tag, logic [7:0] e);
    string t;
    t = $sformatf("%s.gap%0d", tag, gap_of(sel));
    check({t, ".data_out"}, int'(data_out[sel]), int'(e[7]));
    check({t, ".valid"}, int'(valid[sel]), int'(e[6]));
    check({t, ".busy"}, int'(busy[sel]), int'(e[5]));
    check({t, ".done"}, int'(done[sel]), int'(e[4]));
    check({t, ".frames_sent"}, int'(fs[sel]), int'(e[3:0]));
  endtask
  // expected {data_out, valid, busy, done, frames_sent} at cycle c after the start edge
  function automatic logic [7:0] model(int c, int n, int gap, logic [W-1:0] w);
    int p, l, q, f;
    logic [7:0] r;
    p = W + gap;
    l = n == 0 ? 0 : n * W + (n - 1) * gap;
    r = '0;
    if (c <= l) begin
      q = (c - 1) % p;
      f = c >= W ? (c - W) / p + 1 : 0;
      r[5] = 1'b1;
      if (q < W) begin
        r[6] = 1'b1;
        r[7] = w[W-1-q];
      end
      r[3:0] = 4'(f);
    end else begin
      r[4] = c == l + 1;
      r[3:0] = 4'(n);
    end
    return r;
  endfunction
  task automatic scramble(int sel);
    start[sel] = 1'($urandom);
    use_pattern = 1'($urandom);
    word_in = W'($urandom);
    frames = CW'($urandom);
  endtask
  task automatic run(int sel, logic up, logic [W-1:0] w, int n, string tag);
    logic [W-1:0] ew;
    int l;
    ew = up ? PAT : w;
    l = n == 0 ? 0 : n * W + (n - 1) * gap_of(sel);
    use_pattern = up;
    word_in = w;
    frames = CW'(n);
    start[sel] = 1'b1;
    @(posedge clk); #1;
    scramble(sel);
    for (int c = 1; c <= l + 1; c++) begin
      @(posedge clk); #1;
      check_outs(sel, $sformatf("%s.c%0d", tag, c), model(c, n, gap_of(sel), ew));
      if (c <= l) scramble(sel);
      else start[sel] = 1'b0;
    end
    last_n = n;
  endtask
  task automatic idle(int sel, int k);
    repeat (k) begin
      @(posedge clk); #1;
      check_outs(sel, "idle", {4'b0, 4'(last_n)});
    end
  endtask
  task automatic reset_mid(int sel);
    logic [W-1:0] w;
    int c;
    w = W'($urandom);
    c = 2 * (W + gap_of(sel)) + 3;
    use_pattern = 1'b0;
    word_in = w;
    frames = CW'(3);
    start[sel] = 1'b1;
    @(posedge clk); #1;
    start[sel] = 1'b0;
    repeat (c) @(posedge clk);
    #1;
    check_outs(sel, "pre_rst", model(c, 3, gap_of(sel), w));
    reset = 1'b1;
    #1;
    check_outs(sel, "rst_async", 8'h00);
    @(posedge clk); #1;
    check_outs(sel, "rst_hold", 8'h00);
    reset = 1'b0;
    last_n = 0;
  endtask
  // directed cases then random bursts, once per instance
  initial begin
    int n;
    for (int sel = 0; sel < 2; sel++) begin
      reset = 1'b1;
      #2;
      check_outs(sel, "reset", 8'h00);
      @(negedge clk);
      reset = 1'b0;
      last_n = 0;
      idle(sel, 1);
      run(sel, 1'b1, '0, 1, "pat1");
      idle(sel, 2);
      run(sel, 1'b0, 6'b110_010, 3, "word3");
      run(sel, 1'b1, '0, 2, "pat2_b2b");
      run(sel, 1'b0, W'($urandom), 0, "zero");
      idle(sel, 1);
      reset_mid(sel);
      run(sel, 1'b0, W'($urandom), 1, "after_rst");
      repeat (20) begin
        n = $urandom_range(0, 9) == 0 ? 15 : int'($urandom_range(0, 5));
        run(sel, 1'($urandom), W'($urandom), n, "rand");
        idle(sel, int'($urandom_range(0, 2)));
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sequence_transmitter.md
# sequence_transmitter

Serial pattern transmitter that drives a single-bit stream into the team's shift-register sequence detectors. On a start request it loads either the fixed goal pattern or a caller-supplied word. It then emits that word MSB-first, one bit per clock, for a programmable number of frames, with idle gap bits between frames. It is the stimulus and transmit end of the serial sequence-detection path.

## Interface
Parameters:
- WIDTH, 6: frame length in bits.
- PATTERN, 6'b101_011: goal pattern sent when use_pattern=1.
- GAP, 1: idle cycles (data_out=0, valid=0) between consecutive frames; 0 means back-to-back.
- CNT_W, 4: width of the frame counters.

Ports:
- clk  input  1  clock; all state changes on posedge.
- reset  input  1  asynchronous, active-high; returns the block to IDLE.
- start  input  1  request a burst; sampled only in IDLE.
- use_pattern  input  1  1 selects PATTERN, 0 selects word_in; sampled with start.
- word_in  input  WIDTH  user frame word; sampled with start.
- frames  input  CNT_W  number of frames in the burst; sampled with start.
- data_out  output  1  serial bit, registered.
- valid  output  1  high while data_out carries a frame bit.
- busy  output  1  high from the first bit through the last bit of the burst.
- done  output  1  one-cycle pulse at burst completion.
- frames_sent  output  CNT_W  frames fully emitted in the current or last burst.

## Operation
- FSM states: IDLE, SEND, GAP_ST, FINISH.
- IDLE:
  - start=1 and frames≠0: latch word (PATTERN or word_in), frames, and bit index=WIDTH-1; clear frames_sent; go to SEND.
  - start=1 and frames=0: go to FINISH without sending bits; done pulses and frames_sent=0.
- SEND: drive data_out=word[index] with valid=1 and decrement index.
  - After bit 0, increment frames_sent.
  - If frames_sent now equals frames, go to FINISH.
  - Else, if GAP>0, go to GAP_ST; else reload index=WIDTH-1 and stay in SEND.
- GAP_ST: data_out=0, valid=0, busy=1 for exactly GAP cycles, then reload index and return to SEND.
- FINISH: done=1, busy=0, valid=0 for one cycle, then go to IDLE. frames_sent holds until the next accepted start.
- start outside IDLE is ignored. The latched word and frame count are not affected by input changes during a burst.
- frames_sent saturates at the latched frames value and never wraps within a burst.
- Reset at any time, including mid-frame or mid-gap, forces IDLE on the next evaluation with no partial-frame completion.
- Reset values of all outputs are 0: data_out, valid, busy, done, frames_sent.

## Timing
- start sampled high in IDLE at posedge t: the first bit (word[WIDTH-1]) appears after posedge t+1, and busy rises at the same time.
- Frame k (0-based) occupies cycles t+1+k·(WIDTH+GAP) through t+WIDTH+k·(WIDTH+GAP).
- The last bit of N frames ends at cycle t+N·WIDTH+(N-1)·GAP. done pulses in the following cycle, and busy falls in that same cycle.
- A new start is accepted the cycle after done, once the FSM is back in IDLE. Minimum spacing from one done to the next first bit is 2 cycles.
- frames=0: done pulses at t+1 and busy stays 0.
- Throughput is 1 bit per clock inside a frame. There is no backpressure.

## Structure
- Shared package holds the FSM state encoding (IDLE, SEND, GAP_ST, FINISH), the default PATTERN constant shared with the detectors, and the FOUND/NOT_FOUND output constants.
- One sub-module: gap_counter, a loadable down-counter with a zero flag, reused for the bit index and the gap count.
- Everything else is flat. Use one sequential always block for state and registers, and one combinational block for next state.

## Test plan
- Reset mid-burst: reset at the 3rd bit of frame 2 -> all outputs 0 on the next cycle; a following start with frames=1 behaves normally.
- use_pattern=1, frames=1, GAP=1: data_out = 1,0,1,0,1,1 on cycles t+1..t+6, valid high over the same cycles, done at t+7. When fed into sequence_detector_shift_regs, the detector gives exactly one found pulse.
- use_pattern=0, word_in=6'b110_010, frames=3, GAP=1: 3 frames separated by single 0/invalid cycles, done at t+21, frames_sent=3.
- GAP=0, PATTERN, frames=2: 12 contiguous valid bits, busy high for 12 cycles, detector reports exactly 2 found pulses.
- frames=0: done at t+1, busy never rises, valid never rises, frames_sent=0.
- start toggled and word_in changed during a burst: output stream is unchanged; start asserted in IDLE the cycle after done begins a new burst with first bit one cycle later.
